// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants and types for the instruction fetch buffer.
package inst_fetch_buf_pkg;

  // Default core width, buffer depth and the NOP presented while empty.
  localparam int          DEF_CPU_WIDTH = 32;
  localparam int          DEF_DEPTH     = 4;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

  // Per-cycle buffer operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FB_OP_IDLE = 2'b00,
    FB_OP_POP  = 2'b01,
    FB_OP_PUSH = 2'b10,
    FB_OP_BOTH = 2'b11
  } fb_op_e;

endpackage

// File: rtl/inst_fetch_buf_fb_mem.sv
// Storage array for the fetch buffer: one write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module fb_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed {pc, inst} pair into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer between inst_mem and decode. Holds {pc, inst}
// pairs in FIFO order, presents the head show-ahead, and is cleared by a
// branch/jump flush. fetch_ena gates pc_reg so the PC only moves while
// there is room to catch the fetched instruction.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CPU_WIDTH = DEF_CPU_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CPU_WIDTH-1:0]     in_pc,
  input  logic [CPU_WIDTH-1:0]     in_inst,
  output logic                     in_ready,
  output logic                     fetch_ena,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [CPU_WIDTH-1:0]     out_pc,
  output logic [CPU_WIDTH-1:0]     out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic                   push;
  logic                   pop;
  fb_op_e                 op;
  logic [2*CPU_WIDTH-1:0] wr_data;
  logic [2*CPU_WIDTH-1:0] rd_data;

  // Ready is taken from the registered count only: a full buffer refuses a
  // push even in a cycle where decode pops, keeping in_ready off the
  // out_ready timing path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign fetch_ena = in_ready;
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Classify this cycle's activity for the pointer/count update.
  always_comb begin
    op = fb_op_e'({push, pop});
  end

  // Pointer and occupancy update; flush outranks any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        FB_OP_PUSH: begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          count_q <= count_q + CNT_W'(1);
        end
        FB_OP_POP: begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          count_q <= count_q - CNT_W'(1);
        end
        FB_OP_BOTH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_data = {in_pc, in_inst};

  // A push in the flush cycle is dropped, so it must not touch the array.
  fb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2*CPU_WIDTH)
  ) u_fb_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Empty buffer shows a NOP at pc 0 so decode never sees stale contents.
  assign out_pc   = out_valid ? rd_data[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
  assign out_inst = out_valid ? rd_data[CPU_WIDTH-1:0] : CPU_WIDTH'(INST_NOP);

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: a queue-based reference model holds
// the expected FIFO contents; a monitor checks the DUT head and status
// every cycle against it.
module tb_inst_fetch_buf;
  import inst_fetch_buf_pkg::*;

  localparam int D = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_pc = '0;
  logic [W-1:0] in_inst = '0;
  logic         in_ready;
  logic         fetch_ena;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_inst;
  logic         out_ready = 1'b0;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] sb [$];

  inst_fetch_buf #(.DEPTH(D), .CPU_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .fetch_ena (fetch_ena),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {pc, inst} with the buffer's rules.
  always @(posedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      automatic bit acc = in_valid && (sb.size() < D);
      if (out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back({in_pc, in_inst});
    end
  end

  // Monitor: away from the active edge, compare head and status with the model.
  always @(negedge clk) begin
    automatic int n = sb.size();
    chk("count", 64'(count), 64'(n));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("in_ready", 64'(in_ready), 64'(n != D));
    chk("fetch_ena", 64'(fetch_ena), 64'(n != D));
    if (n != 0) begin
      chk("head_pc", 64'(out_pc), 64'(sb[0][2*W-1:W]));
      chk("head_inst", 64'(out_inst), 64'(sb[0][W-1:0]));
    end else begin
      chk("empty_pc", 64'(out_pc), 64'd0);
      chk("empty_inst", 64'(out_inst), 64'h13);
    end
  end

  task automatic cyc(input logic iv, input logic [W-1:0] pc, input logic [W-1:0] inst,
                     input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pc;
    // Reset
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'h13);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    idle(3);

    // Fill with decode stalled, then a fifth push that must be refused
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(4*i), 32'hA0 + W'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'd16, 32'hA4, 1'b0, 1'b0);
    cyc(1'b1, 32'd16, 32'hA4, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_fetch_ena", 64'(fetch_ena), 64'd0);
    chk("full_head_pc", 64'(out_pc), 64'd0);

    // Drain in order
    in_valid = 1'b0;
    drain();
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_inst", 64'(out_inst), 64'h13);

    // Push and pop together at count 2: count holds, pointers wrap
    pc = 32'h100;
    for (int i = 0; i < 2; i++) begin cyc(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pc, $urandom, 1'b1, 1'b0);
      pc += 4;
      chk("simul_count", 64'(count), 64'd2);
    end
    drain();

    // Flush at count 3 with concurrent push and pop
    for (int i = 0; i < 3; i++) begin cyc(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    cyc(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin cyc(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    drain();

    // Async reset pulsed between edges mid-stream
    for (int i = 0; i < 3; i++) begin cyc(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_inst", 64'(out_inst), 64'h13);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin cyc(1'b1, pc, $urandom, 1'b0, 1'b0); pc += 4; end
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, pc, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0);
      pc += 4;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
